// File: rtl/hellow_world_pio_pkg.sv
// Shared definitions for the hellow_world PIO blocks:
// register word addresses and a ceiling-log2 helper.
package hellow_world_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_BLINK    = 2'd1;
    localparam logic [1:0] ADDR_OUTSET   = 2'd2;
    localparam logic [1:0] ADDR_OUTCLEAR = 2'd3;

    function automatic int clog2(input int unsigned n);
        int r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/hellow_world_led_pio_blink_tick.sv
// Blink prescaler: free-running counter that flips phase
// every BLINK_DIV cycles; sync restarts a high half-period.
module hellow_world_led_pio_blink_tick
    import hellow_world_pio_pkg::*;
#(
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sync,
    output logic phase
);

    localparam int CW = clog2(BLINK_DIV);
    localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
            phase <= 1'b1;
        end else if (sync) begin
            count <= '0;
            phase <= 1'b1;
        end else if (count == LAST) begin
            count <= '0;
            phase <= ~phase;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hellow_world_led_pio.sv
// Avalon-MM LED output PIO with atomic set/clear
// registers and per-bit hardware blink.
module hellow_world_led_pio
    import hellow_world_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 10,
    parameter int unsigned RESET_VALUE = 0,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] blink_mask;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      rd_next;
    logic             wr;
    logic             sync;
    logic             phase;

    assign wr    = chipselect & ~write_n;
    assign sync  = wr & (address == ADDR_BLINK);
    assign wdata = writedata[WIDTH-1:0];

    hellow_world_led_pio_blink_tick #(
        .BLINK_DIV(BLINK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .sync   (sync),
        .phase  (phase)
    );

    always_comb begin
        rd_next = '0;
        unique case (address)
            ADDR_DATA:  rd_next = 32'(data_reg);
            ADDR_BLINK: rd_next = 32'(blink_mask);
            default:    rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_reg   <= RST;
            blink_mask <= '0;
        end else if (wr) begin
            unique case (address)
                ADDR_DATA:     data_reg   <= wdata;
                ADDR_BLINK:    blink_mask <= wdata;
                ADDR_OUTSET:   data_reg   <= data_reg | wdata;
                ADDR_OUTCLEAR: data_reg   <= data_reg & ~wdata;
                default:       data_reg   <= data_reg;
            endcase
        end
    end

    // Blinking bits are gated low during the off half-period.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata <= '0;
            out_port <= RST;
        end else begin
            readdata <= rd_next;
            out_port <= data_reg & ~(blink_mask & {WIDTH{~phase}});
        end
    end

endmodule
